// File: rtl/axis_word_to_byte.sv
// ---------------------------------------------------------------------------
// axis_word_to_byte
//
// Takes DATA_WIDTH-bit AXI4-Stream words and re-emits them as an 8-bit
// AXI4-Stream, least-significant byte first. m_axis_last marks every
// LINE_BYTES-th output byte, whatever its position inside a word.
// The block holds one word at a time and applies back-pressure on both sides.
//
// Ports
//   axi_clk       in   clock, rising edge
//   axi_rsr_m     in   asynchronous active-low reset
//   s_axis_valid  in   upstream word valid
//   s_axis_data   in   upstream word [DATA_WIDTH-1:0]
//   s_axis_ready  out  a word is accepted this cycle if valid
//   m_axis_valid  out  output byte valid
//   m_axis_data   out  output byte [7:0]
//   m_axis_last   out  last byte of the current line
//   m_axis_ready  in   downstream accepts a byte
// ---------------------------------------------------------------------------
module axis_word_to_byte #(
   parameter int DATA_WIDTH = 32,
   parameter int LINE_BYTES = 512
) (
   input  logic                  axi_clk,
   input  logic                  axi_rsr_m,
   input  logic                  s_axis_valid,
   input  logic [DATA_WIDTH-1:0] s_axis_data,
   output logic                  s_axis_ready,
   output logic                  m_axis_valid,
   output logic [7:0]            m_axis_data,
   output logic                  m_axis_last,
   input  logic                  m_axis_ready
);

   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int LCNT_W = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;

   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BYTES - 1);
   localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LINE_BYTES - 1);

   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  full_q, full_d;
   logic [LCNT_W-1:0]     lcnt_q, lcnt_d;

   logic byte_xfer;
   logic word_acc;

   // Slice the held word into bytes so the output mux is a plain array select.
   logic [7:0] word_bytes [BYTES];

   for (genvar gi = 0; gi < BYTES; gi++) begin : g_bytes
      assign word_bytes[gi] = hold_q[gi*8 +: 8];
   end

   // Outputs come only from registers; no input reaches them combinationally.
   assign m_axis_valid = full_q;
   assign m_axis_data  = word_bytes[idx_q];
   assign m_axis_last  = full_q & (lcnt_q == LCNT_LAST);

   // A new word may be taken while the final byte of the current one leaves,
   // which is what gives gap-free streaming. Ready is masked during reset.
   assign s_axis_ready = axi_rsr_m & (~full_q | ((idx_q == IDX_LAST) & m_axis_ready));

   assign byte_xfer = full_q & m_axis_ready;
   assign word_acc  = s_axis_valid & s_axis_ready;

   always_comb begin
      hold_d = hold_q;
      idx_d  = idx_q;
      full_d = full_q;
      lcnt_d = lcnt_q;

      if (byte_xfer) begin
         // The line counter runs on output bytes only, independent of words.
         lcnt_d = (lcnt_q == LCNT_LAST) ? '0 : lcnt_q + 1'b1;
         if (idx_q != IDX_LAST) begin
            idx_d = idx_q + 1'b1;
         end else begin
            full_d = 1'b0;
         end
      end

      // A reload in the same cycle as the final byte overrides the drain.
      if (word_acc) begin
         hold_d = s_axis_data;
         idx_d  = '0;
         full_d = 1'b1;
      end
   end

   always_ff @(posedge axi_clk or negedge axi_rsr_m) begin
      if (!axi_rsr_m) begin
         hold_q <= '0;
         idx_q  <= '0;
         full_q <= 1'b0;
         lcnt_q <= '0;
      end else begin
         hold_q <= hold_d;
         idx_q  <= idx_d;
         full_q <= full_d;
         lcnt_q <= lcnt_d;
      end
   end

endmodule
